// File: rtl/arbmux_pkg.sv
// rtl/arbmux_pkg.sv - shared constants and rotated-priority search for the arbitrating mux
package arbmux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Widest channel count the search helper supports; callers zero-extend their request vector.
  localparam int ARB_MAX_M = 32;
  localparam int ARB_IDX_W = $clog2(ARB_MAX_M);

  function automatic logic [ARB_MAX_M-1:0] onehot_first(
    input logic [ARB_MAX_M-1:0] vec,
    input int unsigned          width,
    input int unsigned          start
  );
    logic [ARB_MAX_M-1:0] res;
    logic                 found;
    int unsigned          idx;
    res   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < ARB_MAX_M; i++) begin
      if (i < width) begin
        idx = start + i;
        if (idx >= width) idx = idx - width;
        if (!found && vec[idx[ARB_IDX_W-1:0]]) begin
          res[idx[ARB_IDX_W-1:0]] = 1'b1;
          found                   = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbmux_if.sv
// rtl/arbmux_if.sv - producer-side channels and consumer-side stream of the arbitrating mux
interface arbmux_if #(
  parameter int N = 32,
  parameter int M = 4
) ();

  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_last;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic           out_last;
  logic [N-1:0]   out_data;
  logic [M-1:0]   out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel
  );

endinterface

// File: rtl/arbmux_arbiter.sv
// rtl/arbmux_arbiter.sv - combinational one-hot grant: locked owner, else fixed or rotated priority
module arbmux_arbiter
  import arbmux_pkg::*;
#(
  parameter int M     = 4,
  parameter int MODE  = ARB_RR,
  parameter int PTR_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             lock,
  input  logic [M-1:0]     owner,
  output logic [M-1:0]     grant
);

  logic [ARB_MAX_M-1:0] req_ext;
  logic [ARB_MAX_M-1:0] pick;
  logic [31:0]          start;

  always_comb begin
    req_ext        = '0;
    req_ext[M-1:0] = req;
    start          = (MODE == ARB_RR) ? 32'(ptr) : 32'd0;
    pick           = onehot_first(req_ext, M, start);
    // A locked owner that drops valid yields no grant at all, leaving a bubble.
    grant          = lock ? (owner & req) : pick[M-1:0];
  end

endmodule

// File: rtl/arbmux.sv
// rtl/arbmux.sv - M-input valid/ready mux with internal arbitration, packet lock and one output register
module arbmux
  import arbmux_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int MODE = ARB_RR
) (
  input  logic clk,
  input  logic nreset,
  arbmux_if.slave bus
);

  localparam int PTR_W = (M > 1) ? $clog2(M) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [M-1:0]     owner_q, owner_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [M-1:0]     out_sel_q, out_sel_d;

  logic [M-1:0]     grant;
  logic             adv;
  logic             load;
  logic [N-1:0]     data_sel;
  logic             last_sel;
  logic [PTR_W-1:0] gidx;

  arbmux_arbiter #(
    .M     (M),
    .MODE  (MODE),
    .PTR_W (PTR_W)
  ) u_arbiter (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .lock  (lock_q),
    .owner (owner_q),
    .grant (grant)
  );

  always_comb begin
    adv      = ~out_valid_q | bus.out_ready;
    load     = adv & (|grant);
    data_sel = '0;
    gidx     = '0;
    for (int i = 0; i < M; i++) begin
      data_sel = data_sel | (bus.in_data[i*N +: N] & {N{grant[i]}});
      if (grant[i]) gidx = PTR_W'(i);
    end
    last_sel = |(bus.in_last & grant);

    ptr_d       = ptr_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;

    if (adv) out_valid_d = |grant;
    if (load) begin
      out_data_d = data_sel;
      out_last_d = last_sel;
      out_sel_d  = grant;
      lock_d     = ~last_sel;
      owner_d    = grant;
      // Only packet ends rotate priority, so a packet's beats never reshuffle the order.
      if (last_sel) ptr_d = (gidx == PTR_W'(M - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = grant & {M{adv}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_arbmux.sv
// tb/tb_arbmux.sv - directed bench: round-robin and fixed-priority instances of arbmux
module tb_arbmux;

  logic clk;
  logic nreset;
  int   checks;
  int   failures;

  arbmux_if #(.N(32), .M(4)) rr_if ();
  arbmux_if #(.N(32), .M(4)) fp_if ();

  arbmux #(.N(32), .M(4), .MODE(1)) u_rr (.clk(clk), .nreset(nreset), .bus(rr_if));
  arbmux #(.N(32), .M(4), .MODE(0)) u_fp (.clk(clk), .nreset(nreset), .bus(fp_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nreset   = 1'b0;
    rr_if.in_valid = '0; rr_if.in_last = '0; rr_if.in_data = '0; rr_if.out_ready = 1'b1;
    fp_if.in_valid = '0; fp_if.in_last = '0; fp_if.in_data = '0; fp_if.out_ready = 1'b1;
    tick(); tick();
    chk("reset_out_valid", 64'(rr_if.out_valid), 64'd0);
    chk("reset_out_data",  64'(rr_if.out_data),  64'd0);
    chk("reset_out_sel",   64'(rr_if.out_sel),   64'd0);
    chk("reset_out_last",  64'(rr_if.out_last),  64'd0);
    nreset = 1'b1;
    tick();

    // single source on ch1
    rr_if.in_valid = 4'b0010; rr_if.in_last = 4'b1111;
    rr_if.in_data  = {32'h0, 32'h0, 32'hA5, 32'h0};
    #1 chk("single_in_ready", 64'(rr_if.in_ready), 64'b0010);
    tick();
    chk("single_out_valid", 64'(rr_if.out_valid), 64'd1);
    chk("single_out_data",  64'(rr_if.out_data),  64'hA5);
    chk("single_out_sel",   64'(rr_if.out_sel),   64'b0010);
    chk("single_out_last",  64'(rr_if.out_last),  64'd1);
    rr_if.in_valid = 4'b0000;
    tick();
    chk("idle_out_valid", 64'(rr_if.out_valid), 64'd0);

    // ptr is 2: ch3 wins, ptr wraps to 0
    rr_if.in_valid = 4'b1000; rr_if.in_data = {32'h33, 32'h0, 32'h0, 32'h0};
    tick();
    chk("wrap_out_sel", 64'(rr_if.out_sel), 64'b1000);
    rr_if.in_valid = 4'b0000;
    tick();

    // round-robin fairness
    rr_if.in_valid = 4'b1111; rr_if.in_last = 4'b1111;
    rr_if.in_data  = {32'h13, 32'h12, 32'h11, 32'h10};
    #1 chk("rr_first_in_ready", 64'(rr_if.in_ready), 64'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_sel_%0d", k),  64'(rr_if.out_sel),  64'(4'b0001 << (k % 4)));
      chk($sformatf("rr_data_%0d", k), 64'(rr_if.out_data), 64'(32'h10 + (k % 4)));
    end
    rr_if.in_valid = 4'b0000;
    tick();

    // fixed priority: lowest index wins
    fp_if.in_valid = 4'b1110; fp_if.in_last = 4'b1111;
    fp_if.in_data  = {32'h23, 32'h22, 32'h21, 32'h20};
    #1 chk("fp_in_ready_first", 64'(fp_if.in_ready), 64'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fp_sel_%0d", k),      64'(fp_if.out_sel),  64'b0010);
      chk($sformatf("fp_data_%0d", k),     64'(fp_if.out_data), 64'h21);
      chk($sformatf("fp_in_ready_%0d", k), 64'(fp_if.in_ready), 64'b0010);
    end
    fp_if.in_valid = 4'b0000;
    tick();

    // ptr is 0: a ch1 beat moves it to 2
    rr_if.in_valid = 4'b0010; rr_if.in_data = {32'h0, 32'h0, 32'hB1, 32'h0};
    tick();
    chk("pre_lock_sel", 64'(rr_if.out_sel), 64'b0010);

    // packet lock: ch2 three beats with a gap, ch0 waiting
    rr_if.in_valid = 4'b0101; rr_if.in_last = 4'b0001;
    rr_if.in_data  = {32'h0, 32'hC1, 32'h0, 32'h0F};
    #1 chk("lock_b1_in_ready", 64'(rr_if.in_ready), 64'b0100);
    tick();
    chk("lock_b1_data", 64'(rr_if.out_data), 64'hC1);
    chk("lock_b1_last", 64'(rr_if.out_last), 64'd0);
    rr_if.in_data = {32'h0, 32'hC2, 32'h0, 32'h0F};
    #1 chk("lock_b2_in_ready", 64'(rr_if.in_ready), 64'b0100);
    tick();
    chk("lock_b2_data", 64'(rr_if.out_data), 64'hC2);
    rr_if.in_valid = 4'b0001;
    #1 chk("lock_gap_in_ready", 64'(rr_if.in_ready), 64'b0000);
    tick();
    chk("lock_bubble_valid", 64'(rr_if.out_valid), 64'd0);
    rr_if.in_valid = 4'b0101; rr_if.in_last = 4'b0101;
    rr_if.in_data  = {32'h0, 32'hC3, 32'h0, 32'h0F};
    #1 chk("lock_b3_in_ready", 64'(rr_if.in_ready), 64'b0100);
    tick();
    chk("lock_b3_data", 64'(rr_if.out_data), 64'hC3);
    chk("lock_b3_last", 64'(rr_if.out_last), 64'd1);
    rr_if.in_valid = 4'b0001;
    #1 chk("after_lock_in_ready", 64'(rr_if.in_ready), 64'b0001);
    tick();
    chk("after_lock_sel",  64'(rr_if.out_sel),  64'b0001);
    chk("after_lock_data", 64'(rr_if.out_data), 64'h0F);
    rr_if.in_valid = 4'b0000;
    tick();

    // backpressure on ch1 stream
    rr_if.in_valid = 4'b0010; rr_if.in_last = 4'b1111;
    rr_if.in_data  = {32'h0, 32'h0, 32'hD0, 32'h0};
    tick();
    chk("bp_first_data", 64'(rr_if.out_data), 64'hD0);
    rr_if.out_ready = 1'b0;
    rr_if.in_data   = {32'h0, 32'h0, 32'hD1, 32'h0};
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp_in_ready_%0d", k), 64'(rr_if.in_ready), 64'b0000);
      tick();
      chk($sformatf("bp_hold_data_%0d", k),  64'(rr_if.out_data),  64'hD0);
      chk($sformatf("bp_hold_valid_%0d", k), 64'(rr_if.out_valid), 64'd1);
    end
    rr_if.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 64'(rr_if.in_ready), 64'b0010);
    tick();
    chk("bp_d1", 64'(rr_if.out_data), 64'hD1);
    rr_if.in_data = {32'h0, 32'h0, 32'hD2, 32'h0};
    tick();
    chk("bp_d2", 64'(rr_if.out_data), 64'hD2);
    rr_if.in_valid = 4'b0000;
    tick();

    // async reset in the middle of a ch1 packet
    rr_if.in_valid = 4'b0010; rr_if.in_last = 4'b0000;
    rr_if.in_data  = {32'h0, 32'h0, 32'hE1, 32'h0};
    tick();
    chk("mid_pkt_valid", 64'(rr_if.out_valid), 64'd1);
    #1 nreset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rr_if.out_valid), 64'd0);
    chk("async_rst_data",  64'(rr_if.out_data),  64'd0);
    chk("async_rst_sel",   64'(rr_if.out_sel),   64'd0);
    rr_if.in_valid = 4'b1111; rr_if.in_last = 4'b1111;
    rr_if.in_data  = {32'h43, 32'h42, 32'h41, 32'h40};
    nreset = 1'b1;
    #1 chk("post_rst_in_ready", 64'(rr_if.in_ready), 64'b0001);
    tick();
    chk("post_rst_sel",  64'(rr_if.out_sel),  64'b0001);
    chk("post_rst_data", 64'(rr_if.out_data), 64'h40);
    rr_if.in_valid = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
